kim_fifo_ctrl_param: RTL and testbench

//  Parametrised successor FIFO controller: owns write/read pointers, occupancy count and full/empty FSM for an

---
 rtl/kim_fifo_ctrl_param_if.sv | 28 ++
 rtl/kim_fifo_ctrl_param.sv | 140 ++++++++++++++
 tb/tb_kim_fifo_ctrl_param.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kim_fifo_ctrl_param_if.sv
// Stream and memory-port bundle for kim_fifo_ctrl_param.
// The slave modport is the controller's view; master is the producer/consumer/memory side.
interface kim_fifo_ctrl_param_if #(
    parameter int DATA_W = 32,
    parameter int PTR_W  = 3
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [PTR_W-1:0]  mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  s_valid, s_data, m_ready, mem_rdata,
        output s_ready, m_valid, m_data, mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output s_valid, s_data, m_ready, mem_rdata,
        input  s_ready, m_valid, m_data, mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/kim_fifo_ctrl_param.sv
// FIFO controller for an external async-read memory: pointers, occupancy, EMPTY/RUN/FULL FSM,
// optional fall-through bypass, flush, almost-full/empty flags and a peak-occupancy watermark.
module kim_fifo_ctrl_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int BYPASS    = 1,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    kim_fifo_ctrl_param_if.slave  bus,
    output logic [PTR_W:0]        count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_W:0]        peak_count
);

    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_TH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic             BYP_EN     = (BYPASS != 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef logic [DATA_W-1:0] word_t;

    state_e           state, state_nxt;
    logic [PTR_W-1:0] wptr, wptr_nxt;
    logic [PTR_W-1:0] rptr, rptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] peak_nxt;

    logic  hold;
    logic  is_empty;
    logic  is_full;
    logic  show_s;
    logic  s_ready;
    logic  m_valid;
    logic  w_fire;
    logic  r_fire;
    logic  byp;
    logic  wr_en;
    logic  rd_en;
    word_t out_data;

    // Handshake decode. Reset and flush both silence every strobe for the cycle they are high.
    always_comb begin
        hold     = rst | flush;
        is_empty = (state == ST_EMPTY);
        is_full  = (state == ST_FULL);
        show_s   = BYP_EN & is_empty & bus.s_valid;
        s_ready  = ~hold & (~is_full | bus.m_ready);
        m_valid  = ~hold & (~is_empty | (BYP_EN & bus.s_valid));
        w_fire   = bus.s_valid & s_ready;
        r_fire   = m_valid & bus.m_ready;
        byp      = ~hold & show_s & bus.m_ready;
        wr_en    = w_fire & ~byp;
        rd_en    = r_fire & ~byp;
        out_data = show_s ? bus.s_data : bus.mem_rdata;
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = out_data;
    assign bus.mem_we    = wr_en;
    assign bus.mem_waddr = wptr;
    assign bus.mem_wdata = bus.s_data;
    assign bus.mem_raddr = rptr;

    assign almost_full  = (count >= AFULL_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);

    // NOTE: every variable gets its hold value first, so no path through this block leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = count;
        peak_nxt  = peak_count;

        if (hold) begin
            state_nxt = ST_EMPTY;
            wptr_nxt  = '0;
            rptr_nxt  = '0;
            count_nxt = '0;
            peak_nxt  = '0;
        end else begin
            // Pointers wrap by compare so non-power-of-2 depths skip the unused addresses.
            if (wr_en) wptr_nxt = (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
            if (rd_en) rptr_nxt = (rptr == LAST_PTR) ? '0 : rptr + 1'b1;

            unique case ({wr_en, rd_en})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: ;
            endcase

            case (state)
                ST_EMPTY: if (wr_en & ~rd_en) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (wr_en & ~rd_en & (count_nxt == DEPTH_CNT)) state_nxt = ST_FULL;
                    else if (rd_en & ~wr_en & (count_nxt == '0))   state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (rd_en & ~wr_en) state_nxt = ST_RUN;
                default:  state_nxt = ST_EMPTY;
            endcase

            if (count_nxt > peak_count) peak_nxt = count_nxt;
        end
    end

    // NOTE: non-blocking assignments make all registers update together from pre-edge values;
    // the synchronous reset and flush are already folded into the *_nxt terms above.
    always_ff @(posedge clk) begin
        state      <= state_nxt;
        wptr       <= wptr_nxt;
        rptr       <= rptr_nxt;
        count      <= count_nxt;
        peak_count <= peak_nxt;
    end

    // Invariants tying the FSM encoding to the occupancy it stands for.
    a_count_range: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);
    a_empty_state: assert property (@(posedge clk) disable iff (rst) (state == ST_EMPTY) == (count == '0));
    a_full_state:  assert property (@(posedge clk) disable iff (rst) (state == ST_FULL) == (count == DEPTH_CNT));
    a_ptr_range:   assert property (@(posedge clk) disable iff (rst) (wptr <= LAST_PTR) && (rptr <= LAST_PTR));
    a_peak_bound:  assert property (@(posedge clk) disable iff (rst) peak_count >= count);

endmodule

// File: tb/tb_kim_fifo_ctrl_param.sv
// Bench for kim_fifo_ctrl_param: DUT0 (DEPTH=5, no bypass) and DUT1 (DEPTH=4, bypass) share stimulus;
// a queue-based model scores both every cycle alongside table-driven and directed corner sequences.
`timescale 1ns/1ps
module tb_kim_fifo_ctrl_param;
    localparam int DATA_W = 32;
    localparam int D0 = 5;
    localparam int P0 = $clog2(D0);
    localparam int D1 = 4;
    localparam int P1 = $clog2(D1);

    typedef logic [DATA_W-1:0] word_t;

    typedef struct {
        logic       sv;
        word_t      sd;
        logic       mr;
        logic [3:0] cnt;
        logic       sr;
        logic       mv;
        word_t      md;
        logic       af;
        logic       ae;
    } vec_t;

    logic  clk     = 1'b0;
    logic  rst     = 1'b1;
    logic  flush   = 1'b0;
    logic  s_valid = 1'b0;
    word_t s_data  = '0;
    logic  m_ready = 1'b0;
    bit    sb_en   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    kim_fifo_ctrl_param_if #(.DATA_W(DATA_W), .PTR_W(P0)) bus0();
    kim_fifo_ctrl_param_if #(.DATA_W(DATA_W), .PTR_W(P1)) bus1();

    logic [P0:0] count0, peak0;
    logic [P1:0] count1, peak1;
    logic        afull0, aempty0, afull1, aempty1;

    word_t mem0 [1 << P0];
    word_t mem1 [1 << P1];

    assign bus0.s_valid   = s_valid;
    assign bus0.s_data    = s_data;
    assign bus0.m_ready   = m_ready;
    assign bus0.mem_rdata = mem0[bus0.mem_raddr];
    assign bus1.s_valid   = s_valid;
    assign bus1.s_data    = s_data;
    assign bus1.m_ready   = m_ready;
    assign bus1.mem_rdata = mem1[bus1.mem_raddr];

    always @(posedge clk) if (bus0.mem_we) mem0[bus0.mem_waddr] <= bus0.mem_wdata;
    always @(posedge clk) if (bus1.mem_we) mem1[bus1.mem_waddr] <= bus1.mem_wdata;

    kim_fifo_ctrl_param #(.DATA_W(DATA_W), .DEPTH(D0), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0),
        .count(count0), .almost_full(afull0), .almost_empty(aempty0), .peak_count(peak0)
    );

    kim_fifo_ctrl_param #(.DATA_W(DATA_W), .DEPTH(D1), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1),
        .count(count1), .almost_full(afull1), .almost_empty(aempty1), .peak_count(peak1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: contents as a queue, pointers as running write/read totals modulo depth.
    word_t mq [2][$];
    int    mpeak [2];
    int    wtot  [2];
    int    rtot  [2];

    function automatic int depth_of(input int d);
        return (d != 0) ? D1 : D0;
    endfunction

    task automatic model_step(input int d);
        int n  = mq[d].size();
        bit sr = (n < depth_of(d)) || m_ready;
        bit mv = (n > 0) || ((d != 0) && s_valid);
        bit wf = s_valid && sr;
        bit rf = mv && m_ready;
        if (rst || flush) begin
            mq[d].delete();
            mpeak[d] = 0;
            wtot[d]  = 0;
            rtot[d]  = 0;
        end else begin
            if (!(n == 0 && rf)) begin
                if (rf) begin
                    void'(mq[d].pop_front());
                    rtot[d]++;
                end
                if (wf) begin
                    mq[d].push_back(s_data);
                    wtot[d]++;
                end
            end
            if (mq[d].size() > mpeak[d]) mpeak[d] = mq[d].size();
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic sb_check(input int d, input logic sr, input logic mv, input word_t md, input logic we,
                            input logic [31:0] waddr, input logic [31:0] raddr, input logic [31:0] cnt,
                            input logic [31:0] peak, input logic af, input logic ae);
        int    n    = mq[d].size();
        int    dp   = depth_of(d);
        bit    hold = rst || flush;
        bit    e_sr = !hold && ((n < dp) || m_ready);
        bit    e_mv = !hold && ((n > 0) || ((d != 0) && s_valid));
        bit    e_we = e_sr && s_valid && !(n == 0 && e_mv && m_ready);
        string tag  = (d != 0) ? "sb1" : "sb0";
        check({tag, ".s_ready"}, 32'(sr), 32'(e_sr));
        check({tag, ".m_valid"}, 32'(mv), 32'(e_mv));
        if (e_mv) check({tag, ".m_data"}, md, (n > 0) ? mq[d][0] : s_data);
        check({tag, ".mem_we"}, 32'(we), 32'(e_we));
        check({tag, ".waddr"}, waddr, 32'(wtot[d] % dp));
        check({tag, ".raddr"}, raddr, 32'(rtot[d] % dp));
        check({tag, ".count"}, cnt, 32'(n));
        check({tag, ".peak"}, peak, 32'(mpeak[d]));
        check({tag, ".afull"}, 32'(af), 32'(n >= dp - 1));
        check({tag, ".aempty"}, 32'(ae), 32'(n <= 1));
    endtask

    always @(negedge clk) begin
        if (sb_en) begin
            sb_check(0, bus0.s_ready, bus0.m_valid, bus0.m_data, bus0.mem_we, 32'(bus0.mem_waddr),
                     32'(bus0.mem_raddr), 32'(count0), 32'(peak0), afull0, aempty0);
            sb_check(1, bus1.s_ready, bus1.m_valid, bus1.m_data, bus1.mem_we, 32'(bus1.mem_waddr),
                     32'(bus1.mem_raddr), 32'(count1), 32'(peak1), afull1, aempty1);
        end
    end

    task automatic drive(input logic sv, input word_t sd, input logic mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    vec_t  tbl [12];
    word_t got[$];
    int    waddrs[$];
    int    max_cnt;
    int    ph;

    initial begin
        // Inputs change 1 ns after each rising edge; outputs are sampled on the falling edge.
        tick();
        sb_en = 1'b1;
        rst   = 1'b0;
        @(negedge clk);
        check("rst.count0", 32'(count0), 32'd0);
        check("rst.s_ready0", 32'(bus0.s_ready), 32'd1);
        check("rst.m_valid0", 32'(bus0.m_valid), 32'd0);
        check("rst.aempty0", 32'(aempty0), 32'd1);
        check("rst.afull0", 32'(afull0), 32'd0);
        check("rst.peak1", 32'(peak1), 32'd0);
        tick();

        // Fill DEPTH=5 to full, one refused word, then drain in order.
        tbl[0]  = '{1'b1, 32'h10, 1'b0, 4'd0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 32'h11, 1'b0, 4'd1, 1'b1, 1'b1, 32'h10, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 32'h12, 1'b0, 4'd2, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h13, 1'b0, 4'd3, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h14, 1'b0, 4'd4, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'h15, 1'b0, 4'd5, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 32'h00, 1'b1, 4'd5, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'h00, 1'b1, 4'd4, 1'b1, 1'b1, 32'h11, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 32'h00, 1'b1, 4'd3, 1'b1, 1'b1, 32'h12, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h00, 1'b1, 4'd2, 1'b1, 1'b1, 32'h13, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 4'd1, 1'b1, 1'b1, 32'h14, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 32'h00, 1'b1, 4'd0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].sv, tbl[i].sd, tbl[i].mr);
            @(negedge clk);
            check($sformatf("t1[%0d].count", i), 32'(count0), 32'(tbl[i].cnt));
            check($sformatf("t1[%0d].s_ready", i), 32'(bus0.s_ready), 32'(tbl[i].sr));
            check($sformatf("t1[%0d].m_valid", i), 32'(bus0.m_valid), 32'(tbl[i].mv));
            if (tbl[i].mv) check($sformatf("t1[%0d].m_data", i), bus0.m_data, tbl[i].md);
            check($sformatf("t1[%0d].afull", i), 32'(afull0), 32'(tbl[i].af));
            check($sformatf("t1[%0d].aempty", i), 32'(aempty0), 32'(tbl[i].ae));
            tick();
        end
        check("t1.peak", 32'(peak0), 32'd5);

        // Streaming through DEPTH=5: two words of slack, then one in / one out per cycle.
        do_reset();
        max_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            drive(i < 12, word_t'(32'h20 + i), i >= 2);
            @(negedge clk);
            if (int'(count0) > max_cnt) max_cnt = int'(count0);
            if (bus0.mem_we) waddrs.push_back(int'(bus0.mem_waddr));
            if (bus0.m_valid && m_ready) got.push_back(bus0.m_data);
            tick();
        end
        check("t2.reads", 32'(got.size()), 32'd12);
        check("t2.writes", 32'(waddrs.size()), 32'd12);
        for (int k = 0; k < got.size(); k++) check($sformatf("t2.data[%0d]", k), got[k], 32'h20 + k);
        for (int k = 0; k < waddrs.size(); k++) check($sformatf("t2.waddr[%0d]", k), 32'(waddrs[k]), 32'(k % D0));
        check("t2.max_count", 32'(max_cnt), 32'd2);
        check("t2.peak", 32'(peak0), 32'd2);

        // Bypass vs registered first-word latency.
        do_reset();
        drive(1'b1, 32'hAB, 1'b1);
        @(negedge clk);
        check("t3.byp.m_valid", 32'(bus1.m_valid), 32'd1);
        check("t3.byp.m_data", bus1.m_data, 32'hAB);
        check("t3.byp.mem_we", 32'(bus1.mem_we), 32'd0);
        check("t3.nobyp.m_valid", 32'(bus0.m_valid), 32'd0);
        check("t3.nobyp.mem_we", 32'(bus0.mem_we), 32'd1);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("t3.byp.count", 32'(count1), 32'd0);
        check("t3.nobyp.m_valid", 32'(bus0.m_valid), 32'd1);
        check("t3.nobyp.m_data", bus0.m_data, 32'hAB);
        tick();
        drive(1'b1, 32'hCD, 1'b0);
        @(negedge clk);
        check("t3.stall.m_data", bus1.m_data, 32'hCD);
        check("t3.stall.mem_we", 32'(bus1.mem_we), 32'd1);
        tick();
        drive(1'b0, 32'h77, 1'b0);
        @(negedge clk);
        check("t3.stall.count", 32'(count1), 32'd1);
        check("t3.stall.held", bus1.m_data, 32'hCD);
        tick();

        // FULL with simultaneous read and write on DEPTH=4.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, word_t'(32'h40 + i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h99, 1'b0);
        @(negedge clk);
        check("t4.count", 32'(count1), 32'd4);
        check("t4.s_ready", 32'(bus1.s_ready), 32'd0);
        check("t4.afull", 32'(afull1), 32'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, word_t'(32'h44 + i), 1'b1);
            @(negedge clk);
            check($sformatf("t4.rw[%0d].s_ready", i), 32'(bus1.s_ready), 32'd1);
            check($sformatf("t4.rw[%0d].count", i), 32'(count1), 32'd4);
            check($sformatf("t4.rw[%0d].m_data", i), bus1.m_data, 32'h40 + i);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            check($sformatf("t4.drain[%0d]", i), bus1.m_data, 32'h48 + i);
            tick();
        end
        @(negedge clk);
        check("t4.empty", 32'(count1), 32'd0);
        tick();

        // Flush at count 3 with a word offered.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, word_t'(32'h50 + i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h55, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("t5.pre.count", 32'(count0), 32'd3);
        check("t5.mem_we", 32'(bus0.mem_we), 32'd0);
        check("t5.s_ready", 32'(bus0.s_ready), 32'd0);
        check("t5.m_valid", 32'(bus0.m_valid), 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("t5.count", 32'(count0), 32'd0);
        check("t5.peak", 32'(peak0), 32'd0);
        check("t5.post.m_valid", 32'(bus0.m_valid), 32'd0);
        tick();
        drive(1'b1, 32'h56, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        check("t5.resume", bus0.m_data, 32'h56);
        tick();

        // Reset mid-burst at count 2, then clean restart.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, word_t'(32'h60 + i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h62, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t6.mem_we", 32'(bus0.mem_we), 32'd0);
        check("t6.s_ready", 32'(bus0.s_ready), 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("t6.count", 32'(count0), 32'd0);
        check("t6.m_valid", 32'(bus0.m_valid), 32'd0);
        check("t6.aempty", 32'(aempty0), 32'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, word_t'(32'h63 + i), 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            check($sformatf("t6.resume[%0d]", i), bus0.m_data, 32'h63 + i);
            tick();
        end

        // Random traffic, alternating fill-biased and drain-biased phases, occasional flush.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            ph = (c / 75) % 2;
            drive($urandom_range(0, 9) < ((ph != 0) ? 3 : 8), word_t'($urandom),
                  $urandom_range(0, 9) < ((ph != 0) ? 8 : 3));
            flush = ($urandom_range(0, 59) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
